// File: rtl/riscv_core_axi_pkg.sv
// Shared AXI4 read-channel encodings and the I-cache refill FSM state type.
//   axi_burst_e       : ARBURST encodings (FIXED / INCR / WRAP)
//   axi_resp_e        : RRESP encodings (OKAY / EXOKAY / SLVERR / DECERR)
//   icache_rd_state_e : refill master states (IDLE -> AR -> R -> DONE)
//   AXI_SIZE_8B       : ARSIZE for 8-byte beats
package riscv_core_axi_pkg;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10
  } axi_burst_e;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_e;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_AR   = 2'd1,
    RD_R    = 2'd2,
    RD_DONE = 2'd3
  } icache_rd_state_e;

  localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage

// File: rtl/riscv_core_icache_axi_rd_master.sv
// Read-only AXI4 master that refills one I-cache line per request.
// Takes a level request plus miss address, issues a single 4-beat read
// burst, packs the beats into a 256-bit line and pulses o_mem_done for one
// cycle with the line on o_block (o_bus_err flags any bad beat / RLAST).
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_mem_req, i_addr              refill request (held until o_mem_done)
//   o_mem_done, o_block, o_bus_err completion pulse, line, error flag
//   o_ar*/i_arready                AXI AR channel (one outstanding burst)
//   i_r*/o_rready                  AXI R channel
//
// Build option: define RV_ICACHE_CRITICAL_WORD_FIRST_EN to issue a WRAP
// burst starting at the missed doubleword; beats then fill the line
// starting at slot i_addr[4:3] and wrap modulo 4. Without it the burst is
// INCR from the line-aligned address and slots fill 0..3.
module riscv_core_icache_axi_rd_master
  import riscv_core_axi_pkg::*;
#(
  parameter int                     ADDR_WIDTH     = 64,
  parameter int                     AXI_DATA_WIDTH = 64,
  parameter int                     BLOCK_WIDTH    = 256,
  parameter int                     ID_WIDTH       = 4,
  parameter logic [ID_WIDTH-1:0]    AXI_ID         = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_mem_req,
  input  logic [ADDR_WIDTH-1:0]     i_addr,
  output logic                      o_mem_done,
  output logic [BLOCK_WIDTH-1:0]    o_block,
  output logic                      o_bus_err,
  output logic [ADDR_WIDTH-1:0]     o_araddr,
  output logic [7:0]                o_arlen,
  output logic [2:0]                o_arsize,
  output logic [1:0]                o_arburst,
  output logic [ID_WIDTH-1:0]       o_arid,
  output logic                      o_arvalid,
  input  logic                      i_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_rdata,
  input  logic [1:0]                i_rresp,
  input  logic                      i_rlast,
  input  logic                      i_rvalid,
  output logic                      o_rready
);

  localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BLOCK_WIDTH / 8 - 1);
  localparam logic [ADDR_WIDTH-1:0] BEAT_MASK = ~ADDR_WIDTH'(AXI_DATA_WIDTH / 8 - 1);
  localparam int BEAT_OFF = $clog2(AXI_DATA_WIDTH / 8);

  // Burst type, start address and first slot depend on the build option.
  logic [ADDR_WIDTH-1:0] req_araddr;
  logic [CNT_W-1:0]      start_slot;
`ifdef RV_ICACHE_CRITICAL_WORD_FIRST_EN
  localparam axi_burst_e BURST = AXI_BURST_WRAP;
  assign req_araddr = i_addr & BEAT_MASK;
  assign start_slot = i_addr[BEAT_OFF +: CNT_W];
`else
  localparam axi_burst_e BURST = AXI_BURST_INCR;
  assign req_araddr = i_addr & LINE_MASK;
  assign start_slot = '0;
  // Beat-alignment mask only matters for the critical-word-first build.
  logic [ADDR_WIDTH-1:0] unused_beat_mask;
  assign unused_beat_mask = BEAT_MASK;
  logic unused_beat_off;
  assign unused_beat_off = (BEAT_OFF == 0);
`endif

  icache_rd_state_e       state_q, state_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic                   done_q, done_d;
  logic                   bus_err_q, bus_err_d;
  logic                   err_q, err_d;
  logic [ADDR_WIDTH-1:0]  araddr_q, araddr_d;
  logic [BLOCK_WIDTH-1:0] block_q, block_d;
  logic [CNT_W-1:0]       beat_q, beat_d;   // beats received so far
  logic [CNT_W-1:0]       slot_q, slot_d;   // line slot for the next beat
  logic                   last_beat;

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    done_d    = 1'b0;
    bus_err_d = 1'b0;
    err_d     = err_q;
    araddr_d  = araddr_q;
    block_d   = block_q;
    beat_d    = beat_q;
    slot_d    = slot_q;
    last_beat = (beat_q == CNT_W'(BEATS - 1));

    case (state_q)
      RD_IDLE: begin
        if (i_mem_req) begin
          araddr_d  = req_araddr;
          beat_d    = '0;
          slot_d    = start_slot;
          err_d     = 1'b0;
          arvalid_d = 1'b1;
          state_d   = RD_AR;
        end
      end
      RD_AR: begin
        if (i_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_R;
        end
      end
      RD_R: begin
        if (i_rvalid) begin
          block_d[slot_q*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = i_rdata;
          beat_d = beat_q + CNT_W'(1);
          slot_d = slot_q + CNT_W'(1);
          // Bad response, early RLAST or missing RLAST on the final beat.
          err_d  = err_q | (i_rresp != AXI_RESP_OKAY) | (i_rlast != last_beat);
          // Either end marker closes the burst so the cache never stalls.
          if (i_rlast || last_beat) begin
            rready_d  = 1'b0;
            done_d    = 1'b1;
            bus_err_d = err_d;
            state_d   = RD_DONE;
          end
        end
      end
      RD_DONE: state_d = RD_IDLE;
      default: state_d = RD_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= RD_IDLE;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      done_q    <= 1'b0;
      bus_err_q <= 1'b0;
      err_q     <= 1'b0;
      araddr_q  <= '0;
      block_q   <= '0;
      beat_q    <= '0;
      slot_q    <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      done_q    <= done_d;
      bus_err_q <= bus_err_d;
      err_q     <= err_d;
      araddr_q  <= araddr_d;
      block_q   <= block_d;
      beat_q    <= beat_d;
      slot_q    <= slot_d;
    end
  end

  assign o_mem_done = done_q;
  assign o_bus_err  = bus_err_q;
  assign o_block    = block_q;
  assign o_araddr   = araddr_q;
  assign o_arlen    = 8'(BEATS - 1);
  assign o_arsize   = AXI_SIZE_8B;
  assign o_arburst  = BURST;
  assign o_arid     = AXI_ID;
  assign o_arvalid  = arvalid_q;
  assign o_rready   = rready_q;

endmodule

// File: doc/riscv_core_icache_axi_rd_master.md
Name: riscv_core_icache_axi_rd_master

Overview:
- Read-only AXI4 master between the I-cache and the system interconnect.
- Accepts a block-refill request (level request plus 64-bit address) from the I-cache controller.
- Issues one 4-beat INCR read burst on a 64-bit AXI bus and packs the beats into a 256-bit line.
- Returns the line with a one-cycle done pulse.

Parameters:
- ADDR_WIDTH, 64, address width of the request and of ARADDR.
- AXI_DATA_WIDTH, 64, AXI R-channel data width in bits.
- BLOCK_WIDTH, 256, cache line width in bits; BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH = 4.
- ID_WIDTH, 4, ARID/RID width.
- AXI_ID, 0, constant ARID driven on every request.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_mem_req  in  1  refill request from the cache controller, held high until o_mem_done
- i_addr  in  ADDR_WIDTH  miss address from the cache controller
- o_mem_done  out  1  one-cycle pulse: o_block is valid
- o_block  out  BLOCK_WIDTH  assembled line; beat k occupies bits [k*64 +: 64]
- o_bus_err  out  1  pulses with o_mem_done if any beat returned a non-OKAY response
- o_araddr  out  ADDR_WIDTH  burst start address
- o_arlen  out  8  burst length minus 1, constant 3
- o_arsize  out  3  constant 3 (8 bytes per beat)
- o_arburst  out  2  INCR (2b01); WRAP (2b10) with the optional feature
- o_arid  out  ID_WIDTH  constant AXI_ID
- o_arvalid  out  1  AR valid
- i_arready  in  1  AR ready
- i_rdata  in  AXI_DATA_WIDTH  read data
- i_rresp  in  2  read response
- i_rlast  in  1  last beat
- i_rvalid  in  1  R valid
- o_rready  out  1  R ready

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset values: state = IDLE; o_arvalid = 0, o_rready = 0, o_mem_done = 0, o_bus_err = 0, o_block = 0, o_araddr = 0, beat counter = 0, error flag = 0.
- The FSM is IDLE -> AR -> R -> DONE -> IDLE.
- IDLE:
  - When i_mem_req = 1, latch o_araddr = {i_addr[ADDR_WIDTH-1:5], 5'b0}.
  - Clear the beat counter and error flag, then go to AR.
- AR:
  - o_arvalid = 1.
  - o_araddr, o_arlen, o_arsize and o_arburst stay stable until the handshake (i_arready = 1).
  - On the handshake: o_arvalid drops and the state goes to R.
  - Ready may be high in the same cycle valid rises; that handshake completes in 1 cycle.
- R:
  - o_rready = 1.
  - Each cycle with i_rvalid = 1 writes i_rdata into o_block slot [cnt] and increments the 2-bit counter.
  - If i_rresp != 2'b00, the error flag is set (sticky).
  - A beat with i_rlast = 1, or the 4th beat, moves the state to DONE.
  - If i_rlast arrives early, or is missing on beat 4, the error flag is set and the state still moves to DONE.
  - Gaps in i_rvalid (RVALID low) are tolerated indefinitely.
- DONE:
  - o_mem_done = 1 and o_bus_err = error flag, for exactly 1 cycle. o_rready = 0. Next state is IDLE.
  - o_block holds its value until the next burst's first beat.
- Request handshake:
  - The controller drops i_mem_req on the edge that samples o_mem_done.
  - IDLE accepts a new request the cycle after DONE; back-to-back refills are legal.
- Latency: from i_mem_req rising to o_mem_done is 1 + (AR wait) + 4 beats + 1 cycles. The minimum is 7 cycles.
- i_mem_req dropping mid-burst is ignored; the burst always completes (AXI cannot abort).
- Reset asserted mid-burst: all state clears at once. The interconnect is reset in the same domain, so no orphan beats are expected.
- Only one transaction is outstanding at a time. RID is not checked.

Optional Feature:
- Macro: RV_ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - o_arburst = WRAP.
  - o_araddr = {i_addr[ADDR_WIDTH-1:3], 3'b0}, so the requested doubleword is fetched first.
  - The beat counter starts at i_addr[4:3] and wraps modulo 4. Example: start 2 fills slots 2, 3, 0, 1.
  - Completion is still after 4 beats.
- Undefined: INCR burst with a line-aligned address; slots are filled 0, 1, 2, 3.

Decomposition:
- Package riscv_core_axi_pkg holds:
  - enums axi_burst_e (FIXED/INCR/WRAP) and axi_resp_e (OKAY/EXOKAY/SLVERR/DECERR);
  - enum icache_rd_state_e (IDLE/AR/R/DONE);
  - constant AXI_SIZE_8B = 3'd3.
- No sub-module is needed; the beat packer is a small always_ff inside the FSM module.

Test Plan:
- Basic refill: i_addr = 0x0000_0000_8000_1234, i_arready = 1 at once, 4 consecutive beats 0x11.., 0x22.., 0x33.., 0x44.. with i_rlast on beat 4 -> o_araddr = 0x8000_1220, o_arlen = 3, o_arburst = INCR. o_block = {0x44.., 0x33.., 0x22.., 0x11..}, o_mem_done high for 1 cycle, 7 cycles after the request.
- Backpressure: i_arready delayed 5 cycles and 2-cycle RVALID gaps between beats -> o_araddr held stable. o_arvalid deasserts only after the handshake. The block is correct and o_mem_done pulses exactly once.
- Error: beat 2 returns i_rresp = 2'b10 -> all 4 beats are still consumed, and o_bus_err = 1 together with o_mem_done.
- Reset mid-burst: i_rst_n low after beat 2 -> o_arvalid, o_rready and o_mem_done are 0 immediately. After release, a new request completes normally.
- Back-to-back: a second i_mem_req asserted the cycle after o_mem_done -> the second AR issues with no lost cycle, and the first o_block stays intact until the new beat 0.
- With RV_ICACHE_CRITICAL_WORD_FIRST_EN: i_addr = 0x...1230 -> o_arburst = WRAP and o_araddr = 0x...1230. Beats land in slots 2, 3, 0, 1.
